// File: rtl/pixel_compositor.sv
// Two-stage pixel compositor: priority layer resolve, palette lookup and a
// frame-stepped day/night colour fade.
module pixel_compositor #(
    parameter int N_LAYERS  = 4,
    parameter int CW        = 4,
    parameter int FADE_LOG2 = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [9:0]                       h_cnt,
    input  logic [9:0]                       v_cnt,
    input  logic                             valid,
    input  logic [N_LAYERS-1:0]              layer_hit,
    input  logic                             pal_we,
    input  logic [$clog2(N_LAYERS+1)-1:0]    pal_addr,
    input  logic [3*CW-1:0]                  pal_wdata,
    input  logic                             night_req,
    output logic [CW-1:0]                    vgaRed,
    output logic [CW-1:0]                    vgaGreen,
    output logic [CW-1:0]                    vgaBlue,
    output logic                             night_active,
    output logic                             fading
);

    // state    | meaning
    // DAY      | s = 0, palette colours unchanged
    // TO_NIGHT | s stepping up once per frame
    // NIGHT    | s = F, palette colours fully inverted
    // TO_DAY   | s stepping down once per frame

    localparam int AW = $clog2(N_LAYERS + 1);
    localparam int SW = FADE_LOG2 + 1;
    localparam int W  = CW + FADE_LOG2 + 1;
    localparam int F  = 1 << FADE_LOG2;
    localparam logic [AW-1:0] BG_IDX = AW'(N_LAYERS);
    localparam logic [SW-1:0] F_S    = SW'(F);

    typedef enum logic [1:0] {
        ST_DAY,
        ST_TO_NIGHT,
        ST_NIGHT,
        ST_TO_DAY
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d, s_up, s_dn;
    logic            fs_prev_q, fs_cond, frame_start;
    logic            night_q, night_d, fading_q, fading_d;

    logic [AW-1:0]   idx_q, idx_d;
    logic            vld1_q;
    logic [3*CW-1:0] pal_q [N_LAYERS+1];
    logic [3*CW-1:0] pal_rd;
    logic [3*CW-1:0] rgb_q, rgb_d;

    function automatic logic [CW-1:0] blend_ch(input logic [CW-1:0] c, input logic [SW-1:0] s);
        logic [CW-1:0] ci;
        logic [W-1:0]  acc;
        ci  = ~c;
        acc = W'(c) * W'(F_S - s) + W'(ci) * W'(s);
        return acc[FADE_LOG2 +: CW];
    endfunction

    // Rising-edge detect so counters parked at 0,0 do not re-trigger.
    assign fs_cond     = (h_cnt == '0) && (v_cnt == '0);
    assign frame_start = fs_cond && !fs_prev_q;

    assign s_up = s_q + SW'(1);
    assign s_dn = s_q - SW'(1);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        if (frame_start) begin
            unique case (state_q)
                ST_DAY: begin
                    if (night_req) begin
                        s_d     = s_up;
                        state_d = (s_up == F_S) ? ST_NIGHT : ST_TO_NIGHT;
                    end
                end
                ST_NIGHT: begin
                    if (!night_req) begin
                        s_d     = s_dn;
                        state_d = (s_dn == '0) ? ST_DAY : ST_TO_DAY;
                    end
                end
                default: begin
                    if (night_req) begin
                        s_d     = s_up;
                        state_d = (s_up == F_S) ? ST_NIGHT : ST_TO_NIGHT;
                    end else begin
                        s_d     = s_dn;
                        state_d = (s_dn == '0) ? ST_DAY : ST_TO_DAY;
                    end
                end
            endcase
        end
        night_d  = (state_d == ST_NIGHT);
        fading_d = (state_d == ST_TO_NIGHT) || (state_d == ST_TO_DAY);
    end

    always_comb begin
        idx_d = BG_IDX;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) idx_d = AW'(i);
        end
    end

    // Stage 2 reads the registered palette, so a same-cycle write is not yet visible.
    assign pal_rd = pal_q[idx_q];

    always_comb begin
        rgb_d = '0;
        if (vld1_q) begin
            for (int ch = 0; ch < 3; ch++) begin
                rgb_d[ch*CW +: CW] = blend_ch(pal_rd[ch*CW +: CW], s_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_DAY;
            s_q       <= '0;
            fs_prev_q <= 1'b0;
            night_q   <= 1'b0;
            fading_q  <= 1'b0;
            idx_q     <= '0;
            vld1_q    <= 1'b0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            fs_prev_q <= fs_cond;
            night_q   <= night_d;
            fading_q  <= fading_d;
            idx_q     <= idx_d;
            vld1_q    <= valid;
            rgb_q     <= rgb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= N_LAYERS; i++) begin
                pal_q[i] <= (i == N_LAYERS) ? '1 : '0;
            end
        end else if (pal_we && (pal_addr <= BG_IDX)) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    assign vgaRed       = rgb_q[3*CW-1 -: CW];
    assign vgaGreen     = rgb_q[2*CW-1 -: CW];
    assign vgaBlue      = rgb_q[CW-1 -: CW];
    assign night_active = night_q;
    assign fading       = fading_q;

endmodule
